// File: rtl/spi_master_ctrl_if.sv
// spi_master_ctrl_if: host handshake and SPI pin bundle for spi_master_ctrl.
// The master modport is the controller's view; slave is the host/pin side.
interface spi_master_ctrl_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  start;
   logic [2:0]            sel;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  miso;
   logic                  sclk;
   logic                  mosi;
   logic                  cs_n;
   logic                  busy;
   logic                  done;
   logic [DATA_WIDTH-1:0] rx_data;

   modport master (
      input  start, sel, tx_data, miso,
      output sclk, mosi, cs_n, busy, done, rx_data
   );

   modport slave (
      output start, sel, tx_data, miso,
      input  sclk, mosi, cs_n, busy, done, rx_data
   );
endinterface

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI mode-0 master, one word per start, SCLK half-period 2^sel clks.
// Optional macro SPI_CTRL_LSB_FIRST_EN selects LSB-first shifting (default MSB-first).
// All outputs come straight from flops; rst is asynchronous, active-low.
module spi_master_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int HALF_W     = 8
) (
   input logic               clk,
   input logic               rst,
   spi_master_ctrl_if.master bus
);
   localparam int BW = $clog2(DATA_WIDTH + 1);

   typedef enum logic [1:0] {IDLE, SETUP, XFER, FINISH} state_t;

   state_t                state_q, state_d;
   logic [2:0]            sel_q, sel_d;
   logic [HALF_W-1:0]     half_q, half_d;
   logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                  sclk_q, sclk_d;
   logic                  mosi_q, mosi_d;
   logic                  cs_n_q, cs_n_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   // Half-period reload values: from the live sel when starting, from the
   // captured sel_q during the transfer so sel changes cannot disturb it.
   logic [HALF_W-1:0] start_reload;
   logic [HALF_W-1:0] run_reload;
   assign start_reload = (HALF_W'(1) << bus.sel) - HALF_W'(1);
   assign run_reload   = (HALF_W'(1) << sel_q)   - HALF_W'(1);

   // Bit-order dependent shift paths.
   logic                  tx_first;
   logic [DATA_WIDTH-1:0] tx_shifted;
   logic                  tx_next;
   logic [DATA_WIDTH-1:0] rx_shifted;
`ifdef SPI_CTRL_LSB_FIRST_EN
   assign tx_first   = bus.tx_data[0];
   assign tx_shifted = tx_shift_q >> 1;
   assign tx_next    = tx_shifted[0];
   assign rx_shifted = {bus.miso, rx_shift_q[DATA_WIDTH-1:1]};
`else
   assign tx_first   = bus.tx_data[DATA_WIDTH-1];
   assign tx_shifted = tx_shift_q << 1;
   assign tx_next    = tx_shifted[DATA_WIDTH-1];
   assign rx_shifted = {rx_shift_q[DATA_WIDTH-2:0], bus.miso};
`endif

   // Next-state and next-output logic for the transfer sequencer.
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      half_d     = half_q;
      bit_cnt_d  = bit_cnt_q;
      tx_shift_d = tx_shift_q;
      rx_shift_d = rx_shift_q;
      rx_data_d  = rx_data_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      cs_n_d     = cs_n_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d    = SETUP;
               sel_d      = bus.sel;
               half_d     = start_reload;
               bit_cnt_d  = '0;
               tx_shift_d = bus.tx_data;
               rx_shift_d = '0;
               mosi_d     = tx_first;
               sclk_d     = 1'b0;
               cs_n_d     = 1'b0;
               busy_d     = 1'b1;
            end
         end
         // SETUP is just the first low half-period, so it shares XFER's timing.
         SETUP, XFER: begin
            if (half_q != '0) begin
               half_d = half_q - HALF_W'(1);
            end else begin
               half_d = run_reload;
               if (!sclk_q) begin
                  // Rising edge: sample miso, count the bit.
                  state_d    = XFER;
                  sclk_d     = 1'b1;
                  rx_shift_d = rx_shifted;
                  bit_cnt_d  = bit_cnt_q + BW'(1);
               end else begin
                  // Falling edge: advance mosi unless this closes the last bit.
                  sclk_d = 1'b0;
                  if (bit_cnt_q == BW'(DATA_WIDTH)) begin
                     state_d = FINISH;
                  end else begin
                     tx_shift_d = tx_shifted;
                     mosi_d     = tx_next;
                  end
               end
            end
         end
         FINISH: begin
            state_d   = IDLE;
            cs_n_d    = 1'b1;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            rx_data_d = rx_shift_q;
            mosi_d    = 1'b0;
            half_d    = '0;
            bit_cnt_d = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         sel_q      <= '0;
         half_q     <= '0;
         bit_cnt_q  <= '0;
         tx_shift_q <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         cs_n_q     <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         half_q     <= half_d;
         bit_cnt_q  <= bit_cnt_d;
         tx_shift_q <= tx_shift_d;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
         cs_n_q     <= cs_n_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign bus.sclk    = sclk_q;
   assign bus.mosi    = mosi_q;
   assign bus.cs_n    = cs_n_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.rx_data = rx_data_q;
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: self-checking bench for spi_master_ctrl (DATA_WIDTH=8).
// Define SPI_CTRL_LSB_FIRST_EN for the bench too when building the LSB-first variant.
module tb_spi_master_ctrl;
   localparam int DW = 8;
`ifdef SPI_CTRL_LSB_FIRST_EN
   localparam bit LSB = 1'b1;
`else
   localparam bit LSB = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic loop_en = 1'b0;
   logic miso_bit = 1'b0;
   int   compared = 0;
   int   mismatched = 0;

   spi_master_ctrl_if #(.DATA_WIDTH(DW)) bus ();
   spi_master_ctrl #(.DATA_WIDTH(DW), .HALF_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;
   assign bus.miso = loop_en ? bus.mosi : miso_bit;

   // Reference model: i-th bit on the wire, word assembled from bits in wire order.
   function automatic logic tx_bit(input logic [7:0] w, input int i);
      return LSB ? w[i] : w[7-i];
   endfunction
   function automatic logic [7:0] wire_seq(input logic [7:0] w);
      logic [7:0] s;
      for (int i = 0; i < 8; i++) s[i] = tx_bit(w, i);
      return s;
   endfunction
   function automatic logic [7:0] rx_word(input logic [7:0] seq);
      logic [7:0] w;
      for (int i = 0; i < 8; i++) if (LSB) w[i] = seq[i]; else w[7-i] = seq[i];
      return w;
   endfunction
   function automatic int exp_lat(input logic [2:0] s);
      return 1 + 2 * DW * (1 << s);
   endfunction

   // Runs one transfer, observing the pins each negedge; mvec[i] is miso for wire bit i.
   task automatic do_xfer(input logic [2:0] s, input logic [7:0] tx, input logic loop,
                          input logic [7:0] mvec, input int poke_at, input int abort_rise,
                          output int lat, output logic [7:0] mseq, output int rises,
                          output int half_hi, output int ndone, output logic first_busy,
                          output logic first_csn, output logic [3:0] abort_obs);
      int n;
      int rise_cyc;
      int budget;
      logic prev_sclk;
      logic finished;
      lat = -1; mseq = '0; rises = 0; half_hi = 0; ndone = 0; abort_obs = '0;
      rise_cyc = 0; n = 0; finished = 1'b0; budget = 2 * exp_lat(s) + 50;
      @(negedge clk);
      loop_en = loop; miso_bit = mvec[0];
      bus.sel = s; bus.tx_data = tx; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      first_busy = bus.busy; first_csn = bus.cs_n;
      prev_sclk = bus.sclk;
      while (!finished && n < budget) begin
         @(negedge clk);
         n++;
         if (n == poke_at) begin
            bus.start = 1'b1; bus.tx_data = 8'h00; bus.sel = 3'($urandom);
         end else if (n == poke_at + 1) begin
            bus.start = 1'b0;
         end
         if (bus.sclk && !prev_sclk) begin
            if (rises < 8) mseq[rises] = bus.mosi;
            rises++;
            rise_cyc = n;
            if (rises < 8) miso_bit = mvec[rises];
         end
         if (!bus.sclk && prev_sclk && half_hi == 0) half_hi = n - rise_cyc;
         if (bus.done) begin
            ndone++; lat = n; finished = 1'b1;
         end
         if (abort_rise > 0 && rises == abort_rise) begin
            rst = 1'b0;
            #1 abort_obs = {bus.cs_n, bus.sclk, bus.busy, bus.done};
            finished = 1'b1;
         end
         prev_sclk = bus.sclk;
      end
      if (abort_rise == 0) begin
         repeat (10) begin
            @(negedge clk);
            if (bus.done) ndone++;
         end
      end
      $display("xfer sel=%0d tx=%02h loop=%0d mosi_seq=%02h rises=%0d lat=%0d rx=%02h dones=%0d",
               s, tx, loop, mseq, rises, lat, bus.rx_data, ndone);
   endtask

   task automatic test_reset;
      rst = 1'b0;
      bus.start = 1'b0; bus.sel = 3'd0; bus.tx_data = 8'h00;
      repeat (3) @(negedge clk);
      compared++;
      if ({bus.sclk, bus.mosi, bus.cs_n, bus.busy, bus.done} !== 5'b00100 || bus.rx_data !== 8'h00) begin
         mismatched++;
         $display("FAIL reset_state: got sclk,mosi,cs_n,busy,done=%b rx=%02h, want 00100 rx=00",
                  {bus.sclk, bus.mosi, bus.cs_n, bus.busy, bus.done}, bus.rx_data);
      end
      rst = 1'b1;
      @(negedge clk);
      compared++;
      if (bus.cs_n !== 1'b1 || bus.busy !== 1'b0) begin
         mismatched++;
         $display("FAIL idle_after_reset: cs_n=%b busy=%b, want 1 0", bus.cs_n, bus.busy);
      end
   endtask

   task automatic run_and_check(input string name, input logic [2:0] s, input logic [7:0] tx,
                                input logic loop, input logic [7:0] mvec, input int poke_at);
      int lat, rises, half_hi, ndone;
      logic [7:0] mseq, exp_rx;
      logic fb, fc;
      logic [3:0] ao;
      do_xfer(s, tx, loop, mvec, poke_at, 0, lat, mseq, rises, half_hi, ndone, fb, fc, ao);
      exp_rx = loop ? tx : rx_word(mvec);
      compared++;
      if (lat !== exp_lat(s)) begin
         mismatched++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat(s));
      end
      compared++;
      if (bus.rx_data !== exp_rx) begin
         mismatched++; $display("FAIL %s rx_data: got %02h want %02h", name, bus.rx_data, exp_rx);
      end
      compared++;
      if (mseq !== wire_seq(tx)) begin
         mismatched++; $display("FAIL %s mosi_seq: got %02h want %02h", name, mseq, wire_seq(tx));
      end
      compared++;
      if (rises !== DW || ndone !== 1) begin
         mismatched++; $display("FAIL %s edges/dones: got %0d/%0d want 8/1", name, rises, ndone);
      end
      compared++;
      if (half_hi !== (1 << s)) begin
         mismatched++; $display("FAIL %s half_period: got %0d want %0d", name, half_hi, 1 << s);
      end
      compared++;
      if (fb !== 1'b1 || fc !== 1'b0) begin
         mismatched++; $display("FAIL %s busy/cs_n after accept: got %b/%b want 1/0", name, fb, fc);
      end
   endtask

   task automatic test_loopback_fast;
      run_and_check("loop_a5_sel0", 3'd0, 8'hA5, 1'b1, 8'h00, 0);
   endtask

   task automatic test_slow_ones;
      run_and_check("ones_3c_sel3", 3'd3, 8'h3C, 1'b0, 8'hFF, 0);
   endtask

   task automatic test_sel_max;
      run_and_check("sel7", 3'd7, 8'h96, 1'b0, 8'h4B, 0);
   endtask

   task automatic test_ignore_start;
      run_and_check("ignore_start", 3'd2, 8'h5A, 1'b0, 8'hC3, 20);
   endtask

   task automatic test_lsb_word;
      run_and_check("loop_01", 3'd1, 8'h01, 1'b1, 8'h00, 0);
   endtask

   task automatic test_reset_mid;
      int lat, rises, half_hi, ndone, dn;
      logic [7:0] mseq;
      logic fb, fc;
      logic [3:0] ao;
      do_xfer(3'd2, 8'hE7, 1'b1, 8'h00, 0, 4, lat, mseq, rises, half_hi, ndone, fb, fc, ao);
      compared++;
      if (ao !== 4'b1000) begin
         mismatched++; $display("FAIL abort_outputs: cs_n,sclk,busy,done=%b want 1000", ao);
      end
      repeat (2) @(negedge clk);
      compared++;
      if (bus.rx_data !== 8'h00) begin
         mismatched++; $display("FAIL abort_rx: got %02h want 00", bus.rx_data);
      end
      rst = 1'b1;
      dn = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done || !bus.cs_n) dn++;
      end
      compared++;
      if (dn !== 0) begin
         mismatched++; $display("FAIL abort_no_done: saw %0d active cycles want 0", dn);
      end
      $display("abort at rise 4: obs=%b, restart follows", ao);
      run_and_check("after_abort", 3'd2, 8'h3A, 1'b1, 8'h00, 0);
   endtask

   task automatic test_back_to_back;
      int n, dn, d1, d2, csn_hi;
      logic [7:0] rx1, rx2;
      logic dropped;
      n = 0; dn = 0; d1 = -1; d2 = -1; csn_hi = 0; rx1 = '0; rx2 = '0; dropped = 1'b0;
      @(negedge clk);
      loop_en = 1'b1; bus.sel = 3'd1; bus.tx_data = 8'h81; bus.start = 1'b1;
      @(negedge clk);
      bus.tx_data = 8'h7E;
      while (dn < 2 && n < 300) begin
         @(negedge clk);
         n++;
         if (bus.done) begin
            dn++;
            if (dn == 1) begin d1 = n; rx1 = bus.rx_data; end
            else begin d2 = n; rx2 = bus.rx_data; end
         end
         if (dn == 1 && bus.cs_n) csn_hi++;
         if (dn == 1 && !bus.cs_n && !dropped) begin
            bus.start = 1'b0; dropped = 1'b1;
         end
      end
      bus.start = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) dn++;
      end
      $display("b2b d1=%0d rx1=%02h d2=%0d rx2=%02h cs_n_gap=%0d dones=%0d", d1, rx1, d2, rx2, csn_hi, dn);
      compared++;
      if (d1 !== exp_lat(3'd1) || rx1 !== 8'h81) begin
         mismatched++; $display("FAIL b2b_first: done@%0d rx=%02h want @%0d rx=81", d1, rx1, exp_lat(3'd1));
      end
      compared++;
      if (csn_hi !== 1) begin
         mismatched++; $display("FAIL b2b_cs_gap: got %0d cycles want 1", csn_hi);
      end
      compared++;
      if (d2 !== 2 * exp_lat(3'd1) + 1 || rx2 !== 8'h7E) begin
         mismatched++; $display("FAIL b2b_second: done@%0d rx=%02h want @%0d rx=7e", d2, rx2, 2 * exp_lat(3'd1) + 1);
      end
      compared++;
      if (dn !== 2) begin
         mismatched++; $display("FAIL b2b_done_count: got %0d want 2", dn);
      end
   endtask

   task automatic test_random;
      for (int k = 0; k < 8; k++) begin
         run_and_check("random", 3'($urandom_range(0, 4)), 8'($urandom), 1'b0, 8'($urandom), 0);
      end
   endtask

   initial begin
      test_reset();
      test_loopback_fast();
      test_slow_ones();
      test_sel_max();
      test_ignore_start();
      test_lsb_word();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
